// File: rtl/pipe_execute.sv
// Execute stage (forwarding, ALU, branch resolution) plus the EX/MEM pipeline register.
// Optional branch statistics counters are enabled with `define EXEC_BRANCH_STATS_EN.
module pipe_execute #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_e,
  input  logic [1:0]        result_src_e,
  input  logic              mem_write_e,
  input  logic              jump_e,
  input  logic [1:0]        branch_e,
  input  logic [2:0]        alu_control_e,
  input  logic              alu_src_e,
  input  logic [DATA_W-1:0] rd1_e,
  input  logic [DATA_W-1:0] rd2_e,
  input  logic [DATA_W-1:0] pc_e,
  input  logic [DATA_W-1:0] imm_ext_e,
  input  logic [DATA_W-1:0] pc_plus4_e,
  input  logic [REG_W-1:0]  rd_e,
  input  logic [1:0]        fwd_a_e,
  input  logic [1:0]        fwd_b_e,
  input  logic [DATA_W-1:0] result_w,
  input  logic              stall_m,
  input  logic              flush_m,
  output logic              pc_src_e,
  output logic [DATA_W-1:0] pc_target_e,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic [1:0]        result_src_m,
  output logic [DATA_W-1:0] alu_result_m,
  output logic [DATA_W-1:0] write_data_m,
  output logic [DATA_W-1:0] pc_plus4_m,
  output logic [REG_W-1:0]  rd_m
`ifdef EXEC_BRANCH_STATS_EN
  ,
  output logic [31:0]       br_total,
  output logic [31:0]       br_taken
`endif
);

  logic [DATA_W-1:0] src_a_s;
  logic [DATA_W-1:0] fwd_b_s;
  logic [DATA_W-1:0] src_b_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              cond_s;

  // Operand forwarding; select 11 falls back to the register file value
  always_comb begin
    src_a_s = rd1_e;
    fwd_b_s = rd2_e;
    case (fwd_a_e)
      2'b01:   src_a_s = result_w;
      2'b10:   src_a_s = alu_result_m;
      default: src_a_s = rd1_e;
    endcase
    case (fwd_b_e)
      2'b01:   fwd_b_s = result_w;
      2'b10:   fwd_b_s = alu_result_m;
      default: fwd_b_s = rd2_e;
    endcase
    if (alu_src_e) begin
      src_b_s = imm_ext_e;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  // ALU
  always_comb begin
    alu_result_s = {DATA_W{1'b0}};
    case (alu_control_e)
      3'b000:  alu_result_s = src_a_s + src_b_s;
      3'b001:  alu_result_s = src_a_s - src_b_s;
      3'b010:  alu_result_s = src_a_s & src_b_s;
      3'b011:  alu_result_s = src_a_s | src_b_s;
      3'b100:  alu_result_s = src_a_s ^ src_b_s;
      3'b101:  alu_result_s = {{(DATA_W-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
      3'b110:  alu_result_s = src_a_s << src_b_s[4:0];
      3'b111:  alu_result_s = src_a_s >> src_b_s[4:0];
      default: alu_result_s = {DATA_W{1'b0}};
    endcase
  end

  // Branch compare always uses the forwarded rs2 value, never the immediate
  always_comb begin
    cond_s = 1'b0;
    case (branch_e)
      2'b01:   cond_s = (src_a_s == fwd_b_s);
      2'b10:   cond_s = (src_a_s != fwd_b_s);
      2'b11:   cond_s = ($signed(src_a_s) < $signed(fwd_b_s));
      default: cond_s = 1'b0;
    endcase
  end

  assign pc_src_e    = jump_e | cond_s;
  assign pc_target_e = pc_e + imm_ext_e;

  // EX/MEM register: flush beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      alu_result_m <= {DATA_W{1'b0}};
      write_data_m <= {DATA_W{1'b0}};
      pc_plus4_m   <= {DATA_W{1'b0}};
      rd_m         <= {REG_W{1'b0}};
    end else if (flush_m) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      alu_result_m <= {DATA_W{1'b0}};
      write_data_m <= {DATA_W{1'b0}};
      pc_plus4_m   <= {DATA_W{1'b0}};
      rd_m         <= {REG_W{1'b0}};
    end else if (!stall_m) begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      alu_result_m <= alu_result_s;
      write_data_m <= fwd_b_s;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
    end
  end

`ifdef EXEC_BRANCH_STATS_EN
  logic [31:0] br_total_r;
  logic [31:0] br_taken_r;

  // Branch counters ignore flush_m and wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_total_r <= 32'd0;
      br_taken_r <= 32'd0;
    end else if ((branch_e != 2'b00) && !stall_m) begin
      br_total_r <= br_total_r + 32'd1;
      if (cond_s) begin
        br_taken_r <= br_taken_r + 32'd1;
      end
    end
  end

  assign br_total = br_total_r;
  assign br_taken = br_taken_r;
`endif

endmodule

// File: tb/tb_pipe_execute.sv
// Self-checking bench for pipe_execute: directed vector table, hand-written
// pipeline-control sequences and randomized stimulus against a reference model.
module tb_pipe_execute;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write_e, mem_write_e, jump_e, alu_src_e, stall_m, flush_m;
  logic [1:0]  result_src_e, branch_e, fwd_a_e, fwd_b_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e, result_w;
  logic [4:0]  rd_e;
  logic        pc_src_e, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;
`ifdef EXEC_BRANCH_STATS_EN
  logic [31:0] br_total, br_taken;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_execute #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .branch_e(branch_e), .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e), .pc_plus4_e(pc_plus4_e),
    .rd_e(rd_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .result_w(result_w),
    .stall_m(stall_m), .flush_m(flush_m),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m),
    .rd_m(rd_m)
`ifdef EXEC_BRANCH_STATS_EN
    , .br_total(br_total), .br_taken(br_taken)
`endif
  );

  typedef struct {
    logic [31:0] rd1, rd2, rw, imm, pc;
    logic [1:0]  fa, fb, br;
    logic        jmp, asrc;
    logic [2:0]  op;
    logic [31:0] e_alu, e_wd, e_tgt;
    logic        e_src;
  } vec_t;

  vec_t tbl [12];

  // Reference model state of the EX/MEM register
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd, m_p4;
  logic [4:0]  m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    reg_write_e = 1'b0; mem_write_e = 1'b0; jump_e = 1'b0; alu_src_e = 1'b0;
    stall_m = 1'b0; flush_m = 1'b0; result_src_e = 2'b00; branch_e = 2'b00;
    fwd_a_e = 2'b00; fwd_b_e = 2'b00; alu_control_e = 3'b000;
    rd1_e = 32'd0; rd2_e = 32'd0; pc_e = 32'd0; imm_ext_e = 32'd0;
    pc_plus4_e = 32'd0; result_w = 32'd0; rd_e = 5'd0;
  endtask

  task automatic chk_m(input string tag, input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] p4,
                       input logic [4:0] rd);
    chk({tag, ".reg_write_m"}, 32'(reg_write_m), 32'(rw));
    chk({tag, ".mem_write_m"}, 32'(mem_write_m), 32'(mw));
    chk({tag, ".result_src_m"}, 32'(result_src_m), 32'(rs));
    chk({tag, ".alu_result_m"}, alu_result_m, alu);
    chk({tag, ".write_data_m"}, write_data_m, wd);
    chk({tag, ".pc_plus4_m"}, pc_plus4_m, p4);
    chk({tag, ".rd_m"}, 32'(rd_m), 32'(rd));
  endtask

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      3'd7: return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [1:0] br, input logic [31:0] a,
                                     input logic [31:0] b);
    case (br)
      2'd1: return a == b;
      2'd2: return a != b;
      2'd3: return int'(a) < int'(b);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [31:0] sa, fb, sb;
    clear_in();
    rst_n = 1'b0;
    // order: rd1, rd2, result_w, imm, pc, fwd_a, fwd_b, branch, jump, alu_src, op, alu, wdata, target, pc_src
    tbl[0]  = '{32'd5, 32'd7, 32'd0, 32'd4, 32'h100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 32'd12, 32'd7, 32'h104, 1'b0};
    tbl[1]  = '{32'd3, 32'd5, 32'd0, 32'd4, 32'h100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd1, 32'hFFFFFFFE, 32'd5, 32'h104, 1'b0};
    tbl[2]  = '{32'hF0F0F0F0, 32'd0, 32'd0, 32'h0FF00FF0, 32'h100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 3'd2, 32'h00F000F0, 32'd0, 32'h0FF010F0, 1'b0};
    tbl[3]  = '{32'hF0000000, 32'hF, 32'd0, 32'd4, 32'h100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd3, 32'hF000000F, 32'hF, 32'h104, 1'b0};
    tbl[4]  = '{32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 32'd4, 32'h100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd4, 32'hF0F00F0F, 32'h0F0F0F0F, 32'h104, 1'b0};
    tbl[5]  = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFF8, 32'h100, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 3'd5, 32'd1, 32'd1, 32'hF8, 1'b1};
    tbl[6]  = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFF8, 32'h100, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 3'd5, 32'd1, 32'd1, 32'hF8, 1'b0};
    tbl[7]  = '{32'd1, 32'd1, 32'd0, 32'h24, 32'h100, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 3'd6, 32'h10, 32'd1, 32'h124, 1'b1};
    tbl[8]  = '{32'h80000000, 32'd31, 32'd0, 32'd4, 32'h100, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 3'd7, 32'd1, 32'd31, 32'h104, 1'b1};
    tbl[9]  = '{32'd9, 32'd4, 32'h55, 32'd4, 32'h100, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0, 3'd0, 32'd13, 32'd4, 32'h104, 1'b1};
    tbl[10] = '{32'd5, 32'hFFFFFFFF, 32'd0, 32'd4, 32'h100, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 3'd5, 32'd0, 32'hFFFFFFFF, 32'h104, 1'b0};
    tbl[11] = '{32'd0, 32'h10, 32'h100, 32'd4, 32'h100, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 3'd1, 32'hF0, 32'h10, 32'h104, 1'b0};

    // Reset state
    #2;
    chk_m("reset", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      clear_in();
      rd1_e = tbl[i].rd1; rd2_e = tbl[i].rd2; result_w = tbl[i].rw; imm_ext_e = tbl[i].imm;
      pc_e = tbl[i].pc; fwd_a_e = tbl[i].fa; fwd_b_e = tbl[i].fb; branch_e = tbl[i].br;
      jump_e = tbl[i].jmp; alu_src_e = tbl[i].asrc; alu_control_e = tbl[i].op;
      reg_write_e = 1'b1; rd_e = 5'(i + 1); result_src_e = 2'(i % 3); mem_write_e = 1'(i % 2);
      pc_plus4_e = 32'h200 + 32'(4 * i);
      #1;
      chk($sformatf("tbl%0d.pc_src_e", i), 32'(pc_src_e), 32'(tbl[i].e_src));
      chk($sformatf("tbl%0d.pc_target_e", i), pc_target_e, tbl[i].e_tgt);
      tick();
      chk_m($sformatf("tbl%0d", i), 1'b1, 1'(i % 2), 2'(i % 3), tbl[i].e_alu, tbl[i].e_wd,
            32'h200 + 32'(4 * i), 5'(i + 1));
    end

    // Add with forwarding from the M stage
    clear_in(); rd1_e = 32'h20; tick();
    clear_in(); rd1_e = 32'd5; fwd_a_e = 2'b10; alu_src_e = 1'b1; imm_ext_e = 32'd3;
    tick();
    chk("fwd_m.alu_result_m", alu_result_m, 32'h23);

    // Store data path from the writeback forward
    clear_in(); mem_write_e = 1'b1; fwd_b_e = 2'b01; result_w = 32'hDEADBEEF;
    rd2_e = 32'h1234; alu_src_e = 1'b1;
    tick();
    chk("store.write_data_m", write_data_m, 32'hDEADBEEF);
    chk("store.mem_write_m", 32'(mem_write_m), 32'd1);

    // Stall holds, then flush with stall clears
    clear_in(); reg_write_e = 1'b1; rd_e = 5'd7; tick();
    chk("stall.load_rd_m", 32'(rd_m), 32'd7);
    stall_m = 1'b1; rd_e = 5'd3; reg_write_e = 1'b0; rd1_e = 32'h99;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall.hold_rd_m", 32'(rd_m), 32'd7);
      chk("stall.hold_reg_write_m", 32'(reg_write_m), 32'd1);
    end
    flush_m = 1'b1; mem_write_e = 1'b1; tick();
    chk_m("flush_stall", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);

    // Randomized run against the reference model
    clear_in(); flush_m = 1'b1; tick();
    m_rw = 1'b0; m_mw = 1'b0; m_rs = 2'd0; m_alu = 32'd0; m_wd = 32'd0; m_p4 = 32'd0; m_rd = 5'd0;
    for (int it = 0; it < 400; it++) begin
      rd1_e = $urandom;
      rd2_e = ($urandom_range(0, 3) == 0) ? rd1_e : $urandom;
      result_w = $urandom; imm_ext_e = $urandom; pc_e = $urandom; pc_plus4_e = pc_e + 32'd4;
      alu_control_e = 3'($urandom_range(0, 7)); fwd_a_e = 2'($urandom_range(0, 3));
      fwd_b_e = 2'($urandom_range(0, 3)); alu_src_e = 1'($urandom_range(0, 1));
      jump_e = ($urandom_range(0, 7) == 0); branch_e = 2'($urandom_range(0, 3));
      reg_write_e = 1'($urandom_range(0, 1)); mem_write_e = 1'($urandom_range(0, 1));
      result_src_e = 2'($urandom_range(0, 2)); rd_e = 5'($urandom_range(0, 31));
      stall_m = ($urandom_range(0, 7) == 0); flush_m = ($urandom_range(0, 9) == 0);
      #1;
      sa = ref_fwd(fwd_a_e, rd1_e, result_w, m_alu);
      fb = ref_fwd(fwd_b_e, rd2_e, result_w, m_alu);
      sb = alu_src_e ? imm_ext_e : fb;
      chk("rnd.pc_src_e", 32'(pc_src_e), 32'(jump_e | ref_taken(branch_e, sa, fb)));
      chk("rnd.pc_target_e", pc_target_e, pc_e + imm_ext_e);
      if (flush_m) begin
        m_rw = 1'b0; m_mw = 1'b0; m_rs = 2'd0; m_alu = 32'd0; m_wd = 32'd0; m_p4 = 32'd0; m_rd = 5'd0;
      end else if (!stall_m) begin
        m_rw = reg_write_e; m_mw = mem_write_e; m_rs = result_src_e; m_alu = ref_alu(alu_control_e, sa, sb);
        m_wd = fb; m_p4 = pc_plus4_e; m_rd = rd_e;
      end
      tick();
      chk_m("rnd", m_rw, m_mw, m_rs, m_alu, m_wd, m_p4, m_rd);
    end

    // Asynchronous reset between edges
    clear_in(); reg_write_e = 1'b1; rd_e = 5'd9; rd1_e = 32'h77; result_src_e = 2'd2; tick();
    chk("areset.pre_rd_m", 32'(rd_m), 32'd9);
    #3 rst_n = 1'b0;
    #1;
    chk_m("areset.low", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    chk("areset.held_rd_m", 32'(rd_m), 32'd0);
    #3 rst_n = 1'b1;
    #1;
    chk("areset.released_rd_m", 32'(rd_m), 32'd0);
    tick();
    chk("areset.reload_rd_m", 32'(rd_m), 32'd9);
    chk("areset.reload_alu_result_m", alu_result_m, 32'h77);

`ifdef EXEC_BRANCH_STATS_EN
    chk("stats.total_zero", br_total, 32'd0);
    clear_in(); rd1_e = 32'd42; rd2_e = 32'd42; branch_e = 2'b01;
    repeat (3) tick();
    branch_e = 2'b10;
    repeat (2) tick();
    branch_e = 2'b01; stall_m = 1'b1; tick();
    clear_in(); tick();
    chk("stats.br_total", br_total, 32'd5);
    chk("stats.br_taken", br_taken, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
